wb_fifo_irq_slave: RTL and testbench
====================================

// Module: wb_fifo_irq_slave
// PURPOSE
//  Wishbone B4 pipelined slave on the WB master port of vme64xcore_top_reg.
//  Buffers VME single/BLT/MBLT writes in a 32-bit FIFO and returns them on reads.
//  Raises an interrupt request that the core forwards to VME_IRQ_n_o.
//  Bench counterpart: IVMEMaster writes, then reads back through the core.
// PARAMETERS
//  DEPTH_LOG2  8   FIFO depth = 2**DEPTH_LOG2 words of 32 bits
//  ADR_W       2   width of wb_adr_i (word address; regs at 0..3, rest decode as error)
// PORTS
//  clk_i       in   1      system clock, same clock as core clk_i
//  rst_i       in   1      synchronous reset, active-high
//  wb_cyc_i    in   1      bus cycle
//  wb_stb_i    in   1      strobe; request accepted when cyc&stb&!stall
//  wb_we_i     in   1      1 = write
//  wb_adr_i    in   ADR_W  word address
//  wb_sel_i    in   4      byte selects
//  wb_dat_i    in   32     write data
//  wb_dat_o    out  32     read data, valid with wb_ack_o
//  wb_ack_o    out  1      normal termination
//  wb_err_o    out  1      error termination (core maps this to VME_BERR)
//  wb_stall_o  out  1      back-pressure
//  irq_o       out  1      interrupt request, level, active-high
// BEHAVIOUR
//  Reset: every output is 0. FIFO is empty, pointers are 0, CTRL=0, all sticky bits are 0.
//   Reset mid-transfer drops any pending ack/err.
//  Registers (word address):
//   0 DATA    W pushes, R pops.
//   1 STATUS  RO. [DEPTH_LOG2:0]=level, [16]=empty, [17]=full, [18]=ovf, [19]=udf, [20]=irq_pend.
//   2 CTRL    RW. [0]=irq_en, [1]=clear (self-clearing), [15:8]=threshold.
//   3 IRQACK  W1C. [18]=ovf, [19]=udf, [20]=irq_pend. Reads return 0.
//  Timing: exactly one ack or err per accepted request, registered, in cycle N+1.
//   Back-to-back requests every cycle are sustained.
//   FIFO is synchronous RAM; a DATA pop in cycle N returns mem[rd_ptr] with ack in cycle N+1.
//   If wb_cyc_i is low in cycle N+1, ack/err is suppressed but the side effect stays committed.
//  wb_stall_o is 1 only in the single cycle after a CTRL write with clear=1.
//   During that cycle the pointers and level are zeroed. Sticky bits are kept.
//  DATA write with sel!=4'hF -> err, no push. Other regs ignore sel (full-word access).
//  Push when full: data discarded, ovf<=1, ack (not err).
//  Pop when empty: wb_dat_o=32'h0, pointers unchanged, udf<=1, ack.
//  Address >3 -> err, no side effect, wb_dat_o=0.
//  Level counter is DEPTH_LOG2+1 bits. Pointers are DEPTH_LOG2 bits and wrap naturally.
//   full = level==2**DEPTH_LOG2.
//  IRQ:
//   hit = threshold!=0 && level>=threshold.
//   irq_pend is set on a 0->1 edge of hit, or on any new ovf event.
//   irq_pend is cleared by IRQACK bit20. If set and clear occur in the same cycle, set wins.
//   irq_o = irq_pend & irq_en, registered, 1-cycle latency from irq_pend.
//   With irq_en=0, irq_pend still tracks; setting irq_en later asserts irq_o.
//  Simultaneous events: one request per cycle, so push and pop never coincide.
//   A clear overrides an internal level update in the same cycle.
// STRUCTURE
//  Package wb_fifo_irq_pkg:
//   register offset localparams, STATUS/CTRL bit positions, W1C masks;
//   typedef struct packed ctrl_t {threshold, clear, irq_en}.
//  Sub-module wb_fifo_mem: simple dual-port sync RAM (1 write, 1 registered read port).
//  Top holds decode, pointers/level, sticky bits, IRQ edge logic and WB response pipe.
// TESTING
//  1 Reset, then read STATUS -> 32'h0001_0000 (empty=1, level=0); irq_o=0.
//  2 Write 1,2,3 to DATA; read DATA x3 back-to-back -> 1,2,3, one ack per cycle; then STATUS empty.
//  3 Fill 256 words, push one more -> ack, STATUS full=1, ovf=1, irq_pend=1;
//    256 pops return the original words in order (pointer wrap checked after a second fill).
//  4 CTRL=0x0000_0401 (thr=4, en), push 4 -> irq_o=1 one cycle after irq_pend;
//    IRQACK 0x0010_0000 -> irq_o=0; push 5th -> no new irq.
//  5 Pop empty -> dat 0, udf=1; DATA write with sel=4'h3 -> err; read addr 5 -> err.
//  6 CTRL clear=1 with 10 words queued -> stall 1 cycle, level=0, ovf unchanged;
//    assert rst_i during an active pop -> no ack, all outputs 0.

Source files
------------

// File: rtl/wb_fifo_irq_pkg.sv
// Shared register map, bit positions and control-register layout for the
// Wishbone FIFO/IRQ slave.
package wb_fifo_irq_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_IRQACK = 2'd3;

  localparam int unsigned ST_EMPTY    = 16;
  localparam int unsigned ST_FULL     = 17;
  localparam int unsigned ST_OVF      = 18;
  localparam int unsigned ST_UDF      = 19;
  localparam int unsigned ST_IRQ_PEND = 20;

  localparam int unsigned CTRL_IRQ_EN  = 0;
  localparam int unsigned CTRL_CLEAR   = 1;
  localparam int unsigned CTRL_THR_LSB = 8;

  localparam logic [31:0] W1C_OVF      = 32'h0004_0000;
  localparam logic [31:0] W1C_UDF      = 32'h0008_0000;
  localparam logic [31:0] W1C_IRQ_PEND = 32'h0010_0000;

  typedef struct packed {
    logic [7:0] threshold;
    logic       clear;
    logic       irqEn;
  } ctrl_t;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_ACK,
    RESP_ERR
  } resp_t;

  function automatic ctrl_t unpackCtrl(input logic [31:0] d);
    ctrl_t c;
    c.threshold = d[CTRL_THR_LSB +: 8];
    c.clear     = d[CTRL_CLEAR];
    c.irqEn     = d[CTRL_IRQ_EN];
    return c;
  endfunction

  function automatic logic [31:0] packCtrl(input ctrl_t c);
    logic [31:0] d;
    d = '0;
    d[CTRL_THR_LSB +: 8] = c.threshold;
    d[CTRL_CLEAR]        = c.clear;
    d[CTRL_IRQ_EN]       = c.irqEn;
    return d;
  endfunction

endpackage

// File: rtl/wb_fifo_irq_slave_mem.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module wb_fifo_mem #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  wrEn,
  input  logic [DEPTH_LOG2-1:0] wrAddr,
  input  logic [WIDTH-1:0]      wrData,
  input  logic                  rdEn,
  input  logic [DEPTH_LOG2-1:0] rdAddr,
  output logic [WIDTH-1:0]      rdData
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/wb_fifo_irq_slave.sv
// Wishbone B4 pipelined slave buffering 32-bit words in a FIFO, with status,
// control, W1C interrupt-acknowledge registers and a level interrupt.
module wb_fifo_irq_slave
  import wb_fifo_irq_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned ADR_W      = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_stall_o,
  output logic             irq_o
);

  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(2**DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic [LVL_W-1:0]      level;
  ctrl_t                 ctrl;
  logic                  ovf, udf, irqPend, hitQ, irqQ;
  resp_t                 resp;
  logic                  popQ;
  logic [31:0]           datQ, ramData;

  logic        accept, adrHigh, empty, full, hit;
  logic [1:0]  regSel;
  logic        doPush, doPop, pushFull, popEmpty, ctrlWr, ackWr;
  resp_t       respNext;
  logic [31:0] datNext, statusWord;

  if (ADR_W > 2) begin : gHighAdr
    assign adrHigh = |wb_adr_i[ADR_W-1:2];
  end else begin : gNoHighAdr
    assign adrHigh = 1'b0;
  end

  assign regSel = wb_adr_i[1:0];

  always_comb begin
    // The pending clear bit doubles as the one-cycle stall.
    accept = wb_cyc_i & wb_stb_i & ~ctrl.clear;
    empty  = (level == '0);
    full   = (level == FULL_LVL);
    hit    = (ctrl.threshold != '0) && (32'(level) >= 32'(ctrl.threshold));

    statusWord                = '0;
    statusWord[DEPTH_LOG2:0]  = level;
    statusWord[ST_EMPTY]      = empty;
    statusWord[ST_FULL]       = full;
    statusWord[ST_OVF]        = ovf;
    statusWord[ST_UDF]        = udf;
    statusWord[ST_IRQ_PEND]   = irqPend;

    doPush   = 1'b0;
    pushFull = 1'b0;
    doPop    = 1'b0;
    popEmpty = 1'b0;
    ctrlWr   = 1'b0;
    ackWr    = 1'b0;
    respNext = RESP_NONE;
    datNext  = '0;

    if (accept) begin
      respNext = RESP_ACK;
      if (adrHigh) begin
        respNext = RESP_ERR;
      end else begin
        case (regSel)
          REG_DATA: begin
            if (wb_we_i) begin
              if (wb_sel_i != 4'hF) respNext = RESP_ERR;
              else if (full)        pushFull = 1'b1;
              else                  doPush   = 1'b1;
            end else begin
              if (empty) popEmpty = 1'b1;
              else       doPop    = 1'b1;
            end
          end
          REG_STATUS: begin
            if (!wb_we_i) datNext = statusWord;
          end
          REG_CTRL: begin
            if (wb_we_i) ctrlWr = 1'b1;
            else         datNext = packCtrl(ctrl);
          end
          default: begin
            if (wb_we_i) ackWr = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      level   <= '0;
      ctrl    <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      irqPend <= 1'b0;
      hitQ    <= 1'b0;
      irqQ    <= 1'b0;
      resp    <= RESP_NONE;
      popQ    <= 1'b0;
      datQ    <= '0;
    end else begin
      resp <= respNext;
      popQ <= doPop;
      datQ <= datNext;
      hitQ <= hit;
      irqQ <= irqPend & ctrl.irqEn;

      if (ctrl.clear) begin
        wrPtr      <= '0;
        rdPtr      <= '0;
        level      <= '0;
        ctrl.clear <= 1'b0;
      end else begin
        if (doPush) begin
          wrPtr <= wrPtr + DEPTH_LOG2'(1);
          level <= level + LVL_W'(1);
        end
        if (doPop) begin
          rdPtr <= rdPtr + DEPTH_LOG2'(1);
          level <= level - LVL_W'(1);
        end
      end

      if (ctrlWr) ctrl <= unpackCtrl(wb_dat_i);

      if (ackWr && |(wb_dat_i & W1C_OVF)) ovf <= 1'b0;
      if (pushFull)                       ovf <= 1'b1;
      if (ackWr && |(wb_dat_i & W1C_UDF)) udf <= 1'b0;
      if (popEmpty)                       udf <= 1'b1;

      // Set is written last so it wins over a simultaneous acknowledge.
      if (ackWr && |(wb_dat_i & W1C_IRQ_PEND)) irqPend <= 1'b0;
      if (pushFull || (hit && !hitQ))         irqPend <= 1'b1;
    end
  end

  wb_fifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (32)
  ) uMem (
    .clk   (clk_i),
    .wrEn  (doPush),
    .wrAddr(wrPtr),
    .wrData(wb_dat_i),
    .rdEn  (doPop),
    .rdAddr(rdPtr),
    .rdData(ramData)
  );

  always_comb begin
    wb_ack_o   = (resp == RESP_ACK) & wb_cyc_i & ~rst_i;
    wb_err_o   = (resp == RESP_ERR) & wb_cyc_i & ~rst_i;
    wb_stall_o = ctrl.clear & ~rst_i;
    irq_o      = irqQ & ~rst_i;
    wb_dat_o   = '0;
    if (wb_ack_o) wb_dat_o = popQ ? ramData : datQ;
  end

endmodule

// File: tb/tb_wb_fifo_irq_slave.sv
// Randomized and directed bench for wb_fifo_irq_slave against a queue-based model.
module tb_wb_fifo_irq_slave;

  localparam int unsigned DEPTH = 256;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [2:0]  wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_stall_o, irq_o;

  always #5 clk_i = ~clk_i;

  wb_fifo_irq_slave #(.DEPTH_LOG2(8), .ADR_W(3)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_sel_i  (wb_sel_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o),
    .wb_stall_o(wb_stall_o),
    .irq_o     (irq_o)
  );

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state
  logic [31:0] q[$];
  bit          mOvf, mUdf, mPend, mEn, mHitPrev, mStall;
  logic [7:0]  mThr;
  logic [31:0] lastDat;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic modelReset();
    q.delete();
    mOvf = 0; mUdf = 0; mPend = 0; mEn = 0; mHitPrev = 0; mStall = 0; mThr = '0;
  endtask

  function automatic logic [31:0] statusOf();
    logic [31:0] s;
    s = '0;
    s[8:0] = 9'(q.size());
    s[16]  = (q.size() == 0);
    s[17]  = (q.size() == DEPTH);
    s[18]  = mOvf;
    s[19]  = mUdf;
    s[20]  = mPend;
    return s;
  endfunction

  // One clock of stimulus; expectations derived from the model's pre-edge state.
  task automatic cycle(input bit v, input bit we, input logic [2:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    bit acc, eAck, eErr, hitNow, setPend, eIrq, clrPend, nextStall;
    logic [31:0] eDat;
    wb_cyc_i = v; wb_stb_i = v; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;

    acc = v && !mStall;
    eAck = 0; eErr = 0; eDat = '0; clrPend = 0; nextStall = 0;
    hitNow  = (mThr != 0) && (q.size() >= int'(mThr));
    setPend = hitNow && !mHitPrev;
    eIrq    = mPend && mEn;
    if (mStall) q.delete();

    if (acc) begin
      if (adr > 3) eErr = 1;
      else begin
        case (adr)
          3'd0: begin
            if (we) begin
              if (sel != 4'hF) eErr = 1;
              else begin
                eAck = 1;
                if (q.size() == DEPTH) begin mOvf = 1; setPend = 1; end
                else q.push_back(dat);
              end
            end else begin
              eAck = 1;
              if (q.size() == 0) mUdf = 1;
              else eDat = q.pop_front();
            end
          end
          3'd1: begin
            eAck = 1;
            if (!we) eDat = statusOf();
          end
          3'd2: begin
            eAck = 1;
            if (we) begin
              mEn = dat[0]; mThr = dat[15:8]; nextStall = dat[1];
            end else eDat = {16'h0, mThr, 7'h0, mEn};
          end
          default: begin
            eAck = 1;
            if (we) begin
              if (dat[18]) mOvf = 0;
              if (dat[19]) mUdf = 0;
              clrPend = dat[20];
            end
          end
        endcase
      end
    end
    if (clrPend) mPend = 0;
    if (setPend) mPend = 1;
    mHitPrev = hitNow;
    mStall   = nextStall;

    @(posedge clk_i); #1;
    checkVal("ack", 32'(wb_ack_o), 32'(eAck));
    checkVal("err", 32'(wb_err_o), 32'(eErr));
    checkVal("dat", wb_dat_o, eDat);
    checkVal("irq", 32'(irq_o), 32'(eIrq));
    checkVal("stall", 32'(wb_stall_o), 32'(mStall));
    lastDat = wb_dat_o;
  endtask

  task automatic push(input logic [31:0] d); cycle(1, 1, 3'd0, 4'hF, d); endtask
  task automatic pop();                      cycle(1, 0, 3'd0, 4'hF, '0); endtask
  task automatic idle();                     cycle(0, 0, 3'd0, 4'h0, '0); endtask
  task automatic rd(input logic [2:0] a);    cycle(1, 0, a, 4'hF, '0); endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d); cycle(1, 1, a, 4'hF, d); endtask

  task automatic checkOutputsZero(input string tag);
    checkVal({tag, "_ack"}, 32'(wb_ack_o), 32'h0);
    checkVal({tag, "_err"}, 32'(wb_err_o), 32'h0);
    checkVal({tag, "_stall"}, 32'(wb_stall_o), 32'h0);
    checkVal({tag, "_irq"}, 32'(irq_o), 32'h0);
    checkVal({tag, "_dat"}, wb_dat_o, 32'h0);
  endtask

  initial begin
    rst_i = 1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
    modelReset();
    repeat (3) @(posedge clk_i);
    #1;
    checkOutputsZero("reset");
    rst_i = 0;

    // Reset state
    rd(3'd1);
    checkVal("t1_status", lastDat, 32'h0001_0000);

    // Short write/read-back
    push(32'd1); push(32'd2); push(32'd3);
    pop(); checkVal("t2_pop1", lastDat, 32'd1);
    pop(); pop();
    rd(3'd1);
    checkVal("t2_empty", lastDat, 32'h0001_0000);

    // Fill, overflow, drain, refill across the pointer wrap
    for (int i = 0; i < int'(DEPTH); i++) push($urandom);
    push(32'hDEAD_BEEF);
    rd(3'd1);
    checkVal("t3_full", lastDat, 32'h0016_0100);
    for (int i = 0; i < int'(DEPTH); i++) pop();
    push(32'h1111_2222); pop(); push(32'h3333_4444); pop();
    for (int i = 0; i < int'(DEPTH); i++) push($urandom);
    for (int i = 0; i < int'(DEPTH); i++) pop();
    wr(3'd3, 32'h001C_0000);
    idle();

    // Threshold interrupt
    wr(3'd2, 32'h0000_0401);
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(i));
    repeat (3) idle();
    checkVal("t4_irq_on", 32'(irq_o), 32'h1);
    wr(3'd3, 32'h0010_0000);
    idle();
    checkVal("t4_irq_off", 32'(irq_o), 32'h0);
    push(32'h105);
    repeat (3) idle();
    checkVal("t4_no_new_irq", 32'(irq_o), 32'h0);

    // Underflow, bad sel, bad address
    for (int i = 0; i < 5; i++) pop();
    pop();
    rd(3'd1);
    checkVal("t5_udf", lastDat & 32'h0008_0000, 32'h0008_0000);
    cycle(1, 1, 3'd0, 4'h3, 32'h55);
    rd(3'd5);
    wr(3'd6, 32'h1234);

    // Clear with queued words
    wr(3'd2, 32'h0);
    for (int i = 0; i < 10; i++) push(32'h200 + 32'(i));
    wr(3'd2, 32'h0000_0002);
    cycle(1, 0, 3'd1, 4'hF, '0);
    rd(3'd1);
    checkVal("t6_cleared", lastDat & 32'h0000_01FF, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit v, we;
      logic [2:0] a;
      logic [3:0] s;
      logic [31:0] d;
      v  = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1);
      a  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      s  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      d  = $urandom;
      if (a == 3'd2) d = {16'h0, 8'($urandom_range(0, 12)), 6'h0,
                          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1))};
      cycle(v, we, a, s, d);
    end
    wr(3'd2, 32'h0);
    idle();

    // Reset during an active pop
    push(32'hAAAA_0001); push(32'hBBBB_0002);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 3'd0; wb_sel_i = 4'hF;
    @(posedge clk_i); #1;
    rst_i = 1; #1;
    checkOutputsZero("rst_mid");
    @(posedge clk_i); #1;
    wb_cyc_i = 0; wb_stb_i = 0;
    checkOutputsZero("rst_hold");
    rst_i = 0;
    modelReset();
    rd(3'd1);
    checkVal("rst_status", lastDat, 32'h0001_0000);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
